// File: rtl/audio_mem_arbiter_pkg.sv
// Shared constants and types for the audio sample memory arbiter.
package audio_mem_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;

    // Requester indices into the req_*/resp_* vectors
    localparam int REQ_RECORD = 0;
    localparam int REQ_PLAY   = 1;
    localparam int REQ_MIX    = 2;
    localparam int REQ_PITCH  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/audio_mem_arbiter_rr_picker.sv
// Round-robin picker: the first valid index strictly after last_grant, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   win_o,
    output logic               found_o
);
    import audio_mem_pkg::*;

    // Scan from the farthest slot back to the nearest, so the nearest valid wins
    always_comb begin
        int idx;
        idx     = 0;
        found_o = 1'b0;
        win_o   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant_i) + k) % NUM_REQ;
            if (valid_i[IDX_W'(idx)]) begin
                found_o = 1'b1;
                win_o   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/audio_mem_arbiter.sv
// Arbiter sharing one external sample memory between record, play, mix and pitch.
// One access in flight; record can pre-empt round-robin; accesses time out.
module audio_mem_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = audio_mem_pkg::ADDR_W,
    parameter int DATA_W    = audio_mem_pkg::DATA_W,
    parameter bit PRIO_REQ0 = 1'b1,
    parameter int TIMEOUT   = 255,
    parameter int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               resp_valid,
    output logic [DATA_W-1:0]                resp_rdata,
    output logic                             resp_err,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic                             mem_ack,
    input  logic [DATA_W-1:0]                mem_rdata,
    output logic                             busy,
    output logic [IDX_W-1:0]                 grant_id
);
    import audio_mem_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic                busy_q, busy_d;

    logic [IDX_W-1:0]    rr_win;
    logic                rr_found;
    logic [IDX_W-1:0]    win;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .valid_i      (req_valid),
        .last_grant_i (last_q),
        .win_o        (rr_win),
        .found_o      (rr_found)
    );

    // Record override sits on top of the plain round-robin pick
    always_comb begin
        win = rr_win;
        if (PRIO_REQ0 && req_valid[0]) win = '0;
    end

    // Saturating access timer
    always_comb begin
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                resp_err_d = 1'b0;
                if (rr_found) begin
                    grant_d          = win;
                    mem_req_d        = 1'b1;
                    mem_we_d         = req_we[win];
                    mem_addr_d       = req_addr[win];
                    mem_wdata_d      = req_wdata[win];
                    req_ready_d[win] = 1'b1;
                    busy_d           = 1'b1;
                    cnt_d            = '0;
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_inc;
                if (mem_ack) begin
                    // An ack on the final timeout cycle still counts as success
                    mem_req_d              = 1'b0;
                    resp_err_d             = 1'b0;
                    resp_valid_d[grant_q]  = 1'b1;
                    if (!mem_we_q) resp_rdata_d = mem_rdata;
                    state_d                = RESP;
                end else if (cnt_inc == CNT_MAX) begin
                    mem_req_d              = 1'b0;
                    resp_err_d             = 1'b1;
                    resp_valid_d[grant_q]  = 1'b1;
                    state_d                = RESP;
                end
            end
            RESP: begin
                last_d     = grant_q;
                cnt_d      = '0;
                resp_err_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops everything, including mem_req, at once
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            last_q       <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;

endmodule
